dpram_port_b_sequencer: RTL
===========================

# dpram_port_b_sequencer

Burst sequencer and arbiter for the arithmetic port (port B) of the 2048 x 32 HPS-shared dual-port RAM. Two arithmetic-side requesters submit single-command read or write bursts (base address + length). The block grants one at a time, steps the RAM port-B address/write-enable through the burst one word per cycle, and returns read data and a completion pulse. Port A (HPS register interface) is untouched.

## Interface
- DATA_WIDTH, 32, RAM word width
- ADDR_WIDTH, 11, RAM address width
- LEN_WIDTH, 8, burst length field width (max burst 2**LEN_WIDTH-1 words)

- clock  in  1  single clock, shared with the RAM
- reset  in  1  synchronous, active-high
- reqN_valid  in  1  command valid, N in {0,1}
- reqN_ready  out  1  command accepted when valid&&ready
- reqN_write  in  1  1 = write burst, 0 = read burst
- reqN_addr  in  ADDR_WIDTH  burst base address
- reqN_len  in  LEN_WIDTH  burst length in words
- reqN_wdata  in  DATA_WIDTH  write data for current beat (sampled when wnext=1)
- reqN_wnext  out  1  write beat taken this cycle
- reqN_rdata  out  DATA_WIDTH  read data (q_arith forwarded)
- reqN_rvalid  out  1  rdata valid this cycle
- reqN_done  out  1  one-cycle pulse, burst complete
- addr_arith  out  ADDR_WIDTH  RAM port-B address
- data_arith  out  DATA_WIDTH  RAM port-B write data
- we_arith  out  1  RAM port-B write enable
- q_arith  in  DATA_WIDTH  RAM port-B read data (1-cycle latency)

## Operation
- States: IDLE, BURST, DONE. Reset -> IDLE.
- IDLE: reqN_ready=1 only for the requester chosen by arbitration; command latched on valid&&ready (owner, write, base, len, cnt=0). len=0 -> DONE, else -> BURST.
- BURST: addr_arith = (base+cnt) mod 2**ADDR_WIDTH (wraps 2047 -> 0); we_arith = write; data_arith = owner wdata; owner wnext = write. cnt increments each cycle; after beat cnt=len-1 -> DONE.
- Read beats: owner rvalid=1 in the cycle after each read beat, rdata = q_arith. Non-owner rvalid/wnext/done always 0.
- DONE: owner done=1 for one cycle, ready=0 for both; -> IDLE.
- In IDLE/DONE: we_arith=0, addr_arith=0, data_arith=0.
- Commands presented outside IDLE are held pending (ready=0); requesters must keep fields stable while valid.
- Reset mid-burst: next cycle IDLE, we_arith=0; no further wnext, rvalid or done for the aborted burst.
- Output reset values: all ready/wnext/rvalid/done=0 except arbitration-driven ready in IDLE after reset, we_arith=0, addr_arith=0, data_arith=0, rdata follows q_arith.

## Timing
- Accept at edge ending cycle A; beat k occupies cycle A+1+k; read data for beat k rvalid in cycle A+2+k.
- done in cycle A+1+len (same cycle as last rvalid for reads); earliest next accept in cycle A+2+len.
- len=0: done in cycle A+1, no RAM access.
- ready is combinational from state and both valids; all other control outputs derive from registered state.

## Configuration
- RAMSEQ_ROUND_ROBIN_EN defined: round-robin; when both valid in IDLE, the requester not granted last wins; last-granted register resets to 1 (req0 wins first contest). Single valid always wins.
- Undefined: fixed priority, req0 always wins when both valid.

## Structure
- Package ram_seq_pkg: state enum (IDLE, BURST, DONE), requester-index type, default width constants (32/11/8).
- One sub-module ram_seq_pick: two-input arbiter (round-robin/fixed per macro) returning grant index, holding last-granted register.

## Test plan
- Write burst req0, addr=0x010, len=4, wdata 0xA0..0xA3 -> we_arith=1 at addr 0x010..0x013 in cycles A+1..A+4, wnext 4 cycles, done at A+5.
- Read burst req1, addr=0x010, len=4 -> rvalid A+2..A+5 with rdata 0xA0..0xA3, done at A+5 coinciding with last rvalid.
- Wrap: write len=3 at addr=0x7FF -> addresses 0x7FF, 0x000, 0x001.
- Both valid every cycle from reset, len=1 each -> with macro grants 0,1,0,1; without macro grants 0,0,0 (req1 starved).
- len=0 command -> done at A+1, we_arith never 1, no rvalid.
- reset asserted at beat 2 of a len=8 write -> we_arith=0 next cycle, no done, next command accepted normally.

Source files
------------

// File: rtl/ram_seq_pkg.sv
// -----------------------------------------------------------------------------
// ram_seq_pkg
// Shared types and default widths for the port-B burst sequencer of the
// 2048 x 32 HPS-shared dual-port RAM.
//   state_t    : sequencer FSM states (IDLE, BURST, DONE)
//   req_idx_t  : index of one of the two arithmetic-side requesters
//   DEF_*      : default data / address / burst-length widths
// -----------------------------------------------------------------------------
package ram_seq_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 11;
  localparam int DEF_LEN_WIDTH  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DONE  = 2'd2
  } state_t;

  typedef logic req_idx_t;

endpackage

// File: rtl/ram_seq_pick.sv
// -----------------------------------------------------------------------------
// ram_seq_pick
// Two-input arbiter for the port-B sequencer.
//   i_clock, i_reset : clock and synchronous active-high reset
//   i_valid0/1       : command valid from requester 0 / 1
//   i_accept         : a command is being accepted this cycle (grant taken)
//   o_grant          : index of the requester that wins this cycle
// Build option: RAMSEQ_ROUND_ROBIN_EN
//   defined   -> round-robin; on a contest the requester not granted last
//                wins. Last-granted resets to 1 so req0 wins the first one.
//   undefined -> fixed priority, req0 wins every contest.
// With no valid at all the grant rests on req0.
// -----------------------------------------------------------------------------
module ram_seq_pick
  import ram_seq_pkg::*;
(
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_valid0,
  input  logic i_valid1,
  input  logic i_accept,
  output logic o_grant
);

`ifdef RAMSEQ_ROUND_ROBIN_EN
  req_idx_t r_last;
  req_idx_t w_grant;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_last <= 1'b1;
    end else if (i_accept) begin
      r_last <= w_grant;
    end
  end

  always_comb begin
    w_grant = 1'b0;
    if (i_valid0 && i_valid1) begin
      w_grant = ~r_last;
    end else if (i_valid1) begin
      w_grant = 1'b1;
    end
  end
`else
  req_idx_t w_grant;
  // Fixed priority needs no history; clock/reset/accept are kept on the
  // port list so both builds share one interface.
  logic w_unused;
  assign w_unused = ^{i_clock, i_reset, i_accept};

  always_comb begin
    w_grant = 1'b0;
    if (!i_valid0 && i_valid1) begin
      w_grant = 1'b1;
    end
  end
`endif

  assign o_grant = w_grant;

endmodule

// File: rtl/dpram_port_b_sequencer.sv
// -----------------------------------------------------------------------------
// dpram_port_b_sequencer
// Burst sequencer / arbiter for port B (arithmetic side) of the 2048 x 32
// dual-port RAM. Two requesters submit read or write bursts (base + length);
// one is granted at a time and the burst is stepped one word per cycle.
//   i_clock, i_reset        : clock shared with the RAM, sync active-high reset
//   i_reqN_valid/o_reqN_ready : command handshake (N = 0, 1)
//   i_reqN_write/addr/len   : burst direction, base address, length in words
//   i_reqN_wdata/o_reqN_wnext : write data, taken when wnext = 1
//   o_reqN_rdata/o_reqN_rvalid: read data (q_arith forwarded) and its strobe
//   o_reqN_done             : one-cycle burst-complete pulse
//   o_addr_arith/o_data_arith/o_we_arith : RAM port-B controls
//   i_q_arith               : RAM port-B read data, 1-cycle latency
// Build option: RAMSEQ_ROUND_ROBIN_EN selects round-robin arbitration
// (see ram_seq_pick); fixed priority to req0 otherwise.
// -----------------------------------------------------------------------------
module dpram_port_b_sequencer
  import ram_seq_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int LEN_WIDTH  = DEF_LEN_WIDTH
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_req0_valid,
  output logic                  o_req0_ready,
  input  logic                  i_req0_write,
  input  logic [ADDR_WIDTH-1:0] i_req0_addr,
  input  logic [LEN_WIDTH-1:0]  i_req0_len,
  input  logic [DATA_WIDTH-1:0] i_req0_wdata,
  output logic                  o_req0_wnext,
  output logic [DATA_WIDTH-1:0] o_req0_rdata,
  output logic                  o_req0_rvalid,
  output logic                  o_req0_done,
  input  logic                  i_req1_valid,
  output logic                  o_req1_ready,
  input  logic                  i_req1_write,
  input  logic [ADDR_WIDTH-1:0] i_req1_addr,
  input  logic [LEN_WIDTH-1:0]  i_req1_len,
  input  logic [DATA_WIDTH-1:0] i_req1_wdata,
  output logic                  o_req1_wnext,
  output logic [DATA_WIDTH-1:0] o_req1_rdata,
  output logic                  o_req1_rvalid,
  output logic                  o_req1_done,
  output logic [ADDR_WIDTH-1:0] o_addr_arith,
  output logic [DATA_WIDTH-1:0] o_data_arith,
  output logic                  o_we_arith,
  input  logic [DATA_WIDTH-1:0] i_q_arith
);

  state_t                r_state;
  state_t                w_state_next;
  req_idx_t              r_owner;
  logic                  r_write;
  logic [ADDR_WIDTH-1:0] r_base;
  logic [LEN_WIDTH-1:0]  r_len;
  logic [LEN_WIDTH-1:0]  r_cnt;
  logic                  r_rd_pend;   // a read beat was issued last cycle

  req_idx_t              w_grant;
  logic                  w_idle;
  logic                  w_accept;
  logic                  w_cmd_write;
  logic [ADDR_WIDTH-1:0] w_cmd_addr;
  logic [LEN_WIDTH-1:0]  w_cmd_len;
  logic [LEN_WIDTH-1:0]  w_cnt_inc;
  logic                  w_last_beat;
  logic [ADDR_WIDTH-1:0] w_beat_addr;

  ram_seq_pick u_pick (
    .i_clock  (i_clock),
    .i_reset  (i_reset),
    .i_valid0 (i_req0_valid),
    .i_valid1 (i_req1_valid),
    .i_accept (w_accept),
    .o_grant  (w_grant)
  );

  assign w_idle      = (r_state == IDLE);
  assign w_accept    = w_idle && (w_grant ? i_req1_valid : i_req0_valid);
  assign w_cmd_write = w_grant ? i_req1_write : i_req0_write;
  assign w_cmd_addr  = w_grant ? i_req1_addr  : i_req0_addr;
  assign w_cmd_len   = w_grant ? i_req1_len   : i_req0_len;
  assign w_cnt_inc   = r_cnt + LEN_WIDTH'(1);
  assign w_last_beat = (w_cnt_inc == r_len);
  // Address arithmetic is kept at ADDR_WIDTH bits so the burst wraps at the
  // top of the RAM (2047 -> 0).
  assign w_beat_addr = r_base + ADDR_WIDTH'(r_cnt);

  // State register
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_next = (w_cmd_len == '0) ? DONE : BURST;
        end
      end
      BURST: begin
        if (w_last_beat) begin
          w_state_next = DONE;
        end
      end
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Command latch, beat counter and read-return tracking
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_owner   <= 1'b0;
      r_write   <= 1'b0;
      r_base    <= '0;
      r_len     <= '0;
      r_cnt     <= '0;
      r_rd_pend <= 1'b0;
    end else begin
      r_rd_pend <= (r_state == BURST) && !r_write;
      if (w_accept) begin
        r_owner <= w_grant;
        r_write <= w_cmd_write;
        r_base  <= w_cmd_addr;
        r_len   <= w_cmd_len;
        r_cnt   <= '0;
      end else if (r_state == BURST) begin
        r_cnt <= w_cnt_inc;
      end
    end
  end

  // Outputs: ready is combinational, everything else from registered state.
  always_comb begin
    o_req0_ready  = w_idle && (w_grant == 1'b0);
    o_req1_ready  = w_idle && (w_grant == 1'b1);
    o_req0_wnext  = 1'b0;
    o_req1_wnext  = 1'b0;
    o_req0_rvalid = 1'b0;
    o_req1_rvalid = 1'b0;
    o_req0_done   = 1'b0;
    o_req1_done   = 1'b0;
    o_addr_arith  = '0;
    o_data_arith  = '0;
    o_we_arith    = 1'b0;

    if (r_state == BURST) begin
      o_addr_arith = w_beat_addr;
      o_data_arith = r_owner ? i_req1_wdata : i_req0_wdata;
      o_we_arith   = r_write;
      o_req0_wnext = r_write && (r_owner == 1'b0);
      o_req1_wnext = r_write && (r_owner == 1'b1);
    end

    if (r_state == DONE) begin
      o_req0_done = (r_owner == 1'b0);
      o_req1_done = (r_owner == 1'b1);
    end

    o_req0_rvalid = r_rd_pend && (r_owner == 1'b0);
    o_req1_rvalid = r_rd_pend && (r_owner == 1'b1);
  end

  assign o_req0_rdata = i_q_arith;
  assign o_req1_rdata = i_q_arith;

endmodule
